// File: rtl/vec_write_pkg.sv
// Shared types and helpers for the vector-load write controller.
package vec_write_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    COMMIT,
    DONE,
    ABORT
  } state_t;

  localparam logic MEM_A = 1'b0;
  localparam logic MEM_B = 1'b1;

  function automatic int bytes_per_elem(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Shifts received bytes into an element word, first byte most significant.
module byte_assembler #(
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               rx_ready,
  input  logic [7:0]         rx_data,
  output logic [BYTES*8-1:0] asm_word,
  output logic               elem_complete
);

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CW-1:0] byte_cnt;

  assign elem_complete = rx_ready && (byte_cnt == CW'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      asm_word <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      asm_word <= '0;
      byte_cnt <= '0;
    end else if (rx_ready) begin
      asm_word <= (asm_word << 8) | (BYTES*8)'(rx_data);
      byte_cnt <= elem_complete ? '0 : byte_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vector_write_ctrl.sv
// Loads a vector from UART bytes into memory A or B while begin_write is held,
// reporting completion or an inactivity abort via write_done/write_error.
module vector_write_ctrl
  import vec_write_pkg::*;
#(
  parameter int NUM_ELEMENTOS  = 1024,
  parameter int ELEM_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int BYTES_PER_ELEM = bytes_per_elem(ELEM_WIDTH),
  localparam int AW = (NUM_ELEMENTOS > 1) ? $clog2(NUM_ELEMENTOS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  begin_write,
  input  logic                  mem_sel,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic                  wr_en_a,
  output logic                  wr_en_b,
  output logic [AW-1:0]         wr_addr,
  output logic [ELEM_WIDTH-1:0] wr_data,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_ELEMENTOS - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t state, next_state;

  logic                        begin_write_q;
  logic                        sel;
  logic [AW-1:0]               addr;
  logic [TW-1:0]               timer;
  logic                        start;
  logic                        last_elem;
  logic                        asm_rx;
  logic                        asm_clear;
  logic                        elem_complete;
  logic [BYTES_PER_ELEM*8-1:0] asm_word;

  assign start     = begin_write && !begin_write_q;
  assign last_elem = (addr == LAST_ADDR);
  assign asm_clear = (state == IDLE) && start;

  // A byte landing in COMMIT opens the next element, unless the vector is full.
  assign asm_rx = rx_ready &&
                  (((state == ASSEMBLE) && begin_write) ||
                   ((state == COMMIT) && !last_elem));

  byte_assembler #(
    .BYTES (BYTES_PER_ELEM)
  ) u_byte_assembler (
    .clk           (clk),
    .reset         (reset),
    .clear         (asm_clear),
    .rx_ready      (asm_rx),
    .rx_data       (rx_data),
    .asm_word      (asm_word),
    .elem_complete (elem_complete)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Timer counts only idle ASSEMBLE cycles; any other state restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      begin_write_q <= 1'b0;
      sel           <= MEM_A;
      addr          <= '0;
      timer         <= '0;
    end else begin
      begin_write_q <= begin_write;
      if ((state == IDLE) && start) begin
        sel  <= mem_sel;
        addr <= '0;
      end else if ((state == COMMIT) && !last_elem) begin
        addr <= addr + AW'(1);
      end
      if ((state == ASSEMBLE) && !rx_ready) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = ASSEMBLE;
      end
      ASSEMBLE: begin
        if (!begin_write) begin
          next_state = IDLE;
        end else if (elem_complete) begin
          next_state = COMMIT;
        end else if (!rx_ready && (timer == TIMER_LAST)) begin
          next_state = ABORT;
        end
      end
      COMMIT:  next_state = last_elem ? DONE : ASSEMBLE;
      DONE:    next_state = IDLE;
      ABORT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign wr_en_a     = (state == COMMIT) && (sel == MEM_A);
  assign wr_en_b     = (state == COMMIT) && (sel == MEM_B);
  assign wr_addr     = addr;
  assign wr_data     = asm_word[ELEM_WIDTH-1:0];
  assign write_done  = (state == DONE) || (state == ABORT);
  assign write_error = (state == ABORT);
  assign busy        = (state != IDLE);

endmodule

// File: doc/vector_write_ctrl.md
Name: vector_write_ctrl

Overview:
Sequences the vector-load path: while the control unit's WRITE state holds begin_write, this block assembles UART RX bytes into ELEM_WIDTH-bit elements. It writes each element to memory A or B at incrementing addresses. After NUM_ELEMENTOS elements, or on an RX inactivity timeout, it returns write_done to the control unit. It sits between the UART receiver and the two vector memories.

Parameters:
NUM_ELEMENTOS, 1024, elements per vector; memory depth.
ELEM_WIDTH, 16, element width in bits.
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between RX bytes before abort.
(derived) BYTES_PER_ELEM = ceil(ELEM_WIDTH/8); AW = $clog2(NUM_ELEMENTOS).

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-low reset
begin_write  in  1  level from control unit; a rising edge starts a load
mem_sel  in  1  target memory (0 = A, 1 = B); sampled on the begin_write rising edge
rx_data  in  8  received byte
rx_ready  in  1  one-cycle strobe; rx_data is valid
wr_en_a  out  1  write strobe, memory A
wr_en_b  out  1  write strobe, memory B
wr_addr  out  AW  write address
wr_data  out  ELEM_WIDTH  write data
write_done  out  1  one-cycle pulse; load finished or aborted
write_error  out  1  one-cycle pulse coincident with write_done on timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE. All outputs are 0, and the address, byte counter, assembly register and timeout counter are all 0. Reset mid-load discards the load; no done pulse is issued.
- Start: only on a begin_write rising edge (registered previous value). A level held high after DONE must not restart the load.
- IDLE: on a start edge, latch mem_sel, clear addr and byte_cnt, go to ASSEMBLE.
- ASSEMBLE:
  - On rx_ready: asm <= {asm[..], rx_data} (first byte is most significant) and byte_cnt++.
  - On the rx_ready that supplies byte BYTES_PER_ELEM-1: byte_cnt <= 0, go to COMMIT.
  - Timeout counter clears on every rx_ready and otherwise increments. When it reaches TIMEOUT_CYCLES, go to ABORT.
  - begin_write low: go to IDLE silently; no write, no done.
- COMMIT (1 cycle):
  - The selected wr_en is 1, wr_addr = addr, wr_data = asm[ELEM_WIDTH-1:0]; excess upper bits are dropped.
  - Memory write latency: 1 cycle after the final byte's rx_ready.
  - If addr == NUM_ELEMENTOS-1, go to DONE. Otherwise addr++ and go to ASSEMBLE.
  - An rx_ready arriving in COMMIT is accepted as byte 0 of the next element (byte_cnt = 1 on exit). After the final element it is discarded.
- DONE (1 cycle): write_done = 1, go to IDLE. rx bytes are ignored. Addr does not wrap past NUM_ELEMENTOS-1.
- ABORT (1 cycle): write_done = 1 and write_error = 1, go to IDLE. Already-committed elements remain in memory. A partial element is never written.
- wr_en_a and wr_en_b are never high together, and are only high in COMMIT.
- All outputs are registered or decoded from state only; there is no combinational path from rx_* to wr_*.

Decomposition:
- Package vec_write_pkg: state enum {IDLE, ASSEMBLE, COMMIT, DONE, ABORT}, MEM_A/MEM_B select constants, BYTES_PER_ELEM helper function.
- Sub-module byte_assembler: shift register plus byte counter. Inputs: clk, reset, clear, rx_ready, rx_data. Outputs: asm_word and elem_complete.
- The FSM, address counter and timeout counter live in vector_write_ctrl.

Test Plan:
All scenarios use NUM_ELEMENTOS=4, ELEM_WIDTH=16 and TIMEOUT_CYCLES=50 unless stated.
1. Basic load to A: begin_write rise with mem_sel=0; bytes 12,34,56,78,9A,BC,DE,F0,01,02,... sent 5 cycles apart. Expect wr_en_a pulses addr0=1234, addr1=5678, addr2=9ABC, addr3=DEF0; write_done 1 cycle after the last commit; wr_en_b never high; write_error 0.
2. Load to B: same stimulus with mem_sel=1. Expect only wr_en_b, with identical addr/data.
3. Back-to-back bytes: rx_ready every cycle, including bytes landing in COMMIT cycles. Expect all 4 elements correct with no lost bytes; write_done after the 8th byte plus 2 cycles.
4. Timeout: send 3 bytes (AA,BB,CC) then stop. Expect one commit (addr0=AABB); write_done and write_error both high 50 cycles after CC; no write of CC.
5. Reset mid-load: drive reset low after 5 bytes. Expect all outputs 0 the next cycle and no done. A new begin_write rise restarts at addr 0.
6. Truncation, with ELEM_WIDTH=10: bytes 03,FF then FF,FF. Expect wr_data 3FF for both elements. Also hold begin_write high after DONE and expect no restart.
